// File: rtl/pc_sequencer.sv
// Program-counter sequencer: fetches one instruction word, holds it for a
// single EXEC cycle, then selects the next pc (sequential, branch, jump, jr).
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_data,
    output logic [31:0] inst,
    output logic        inst_valid,
    output logic [31:0] pc,
    input  logic        halted,
    input  logic        branch,
    input  logic        jump,
    input  logic        jump_register,
    input  logic [31:0] rs_data,
    output logic        halt_done,
    output logic        misaligned,
    output logic [31:0] retired,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_WAIT   = 2'd1,
        S_EXEC   = 2'd2,
        S_HALTED = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc4;
    logic [31:0] pc_target;
    logic        jr_bad;
    logic        fetching;

    // Fetch handshake: imem_req is raised with a stable imem_addr in FETCH/WAIT
    // and held until a cycle where imem_ready=1; that cycle's imem_data is taken.
    assign fetching  = (state == S_FETCH) || (state == S_WAIT);
    assign pc4       = pc + 32'd4;
    assign jr_bad    = jump_register && (rs_data[1:0] != 2'b00);
    assign imem_addr = pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_FETCH, S_WAIT: state_next = imem_ready ? S_EXEC : S_WAIT;
            S_EXEC:          state_next = (halted || jr_bad) ? S_HALTED : S_FETCH;
            S_HALTED:        state_next = S_HALTED;
            default:         state_next = S_FETCH;
        endcase
    end

    always_comb begin
        imem_req   = fetching && !rst;
        inst_valid = (state == S_EXEC);
        halt_done  = (state == S_HALTED);
        state_dbg  = state;
    end

    // Halt outranks every redirect; a bad jr target keeps pc on the offender.
    always_comb begin
        pc_target = pc4;
        if (halted) begin
            pc_target = pc;
        end else if (jump_register) begin
            pc_target = jr_bad ? pc : rs_data;
        end else if (jump) begin
            pc_target = {pc4[31:28], inst[25:0], 2'b00};
        end else if (branch) begin
            pc_target = pc4 + {{14{inst[15]}}, inst[15:0], 2'b00};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc         <= RESET_PC;
            inst       <= 32'h0;
            retired    <= 32'h0;
            misaligned <= 1'b0;
        end else begin
            if (fetching && imem_ready) begin
                inst <= imem_data;
            end
            if (state == S_EXEC) begin
                pc      <= pc_target;
                retired <= retired + 32'd1;
                if (!halted && jr_bad) begin
                    misaligned <= 1'b1;
                end
            end
        end
    end

endmodule
